// File: rtl/acc_link_seq.sv
// Accumulator/link register with a sequenced group-1 micro-op engine.
// Optional feature: define ACC_BSW_EN to make a lone BSW swap the AC halves.
module acc_link_seq (
  input  logic        CLK,
  input  logic        RESET_,
  input  logic [11:0] SUM,
  input  logic        CARRY,
  input  logic [11:0] LOGIC,
  input  logic        LD_ADD,
  input  logic        LD_AND,
  input  logic        CLR_AC,
  input  logic [7:0]  OPR,
  input  logic        OPR_START,
  output logic [11:0] AC,
  output logic        LINK,
  output logic        BUSY,
  output logic        DONE
);

  localparam int unsigned W  = 12;
  localparam int unsigned OW = 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_CMP  = 3'd2;
  localparam logic [2:0] S_INC  = 3'd3;
  localparam logic [2:0] S_ROT1 = 3'd4;
  localparam logic [2:0] S_ROT2 = 3'd5;
  localparam logic [2:0] S_FIN  = 3'd6;

  localparam int unsigned B_CLA = 7;
  localparam int unsigned B_CLL = 6;
  localparam int unsigned B_CMA = 5;
  localparam int unsigned B_CML = 4;
  localparam int unsigned B_RAR = 3;
  localparam int unsigned B_RAL = 2;
  localparam int unsigned B_BSW = 1;
  localparam int unsigned B_IAC = 0;

  logic [2:0]    state_q, state_d;
  logic [OW-1:0] opr_q, opr_d;
  logic [W-1:0]  ac_q, ac_d;
  logic          link_q, link_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [W:0]    inc_c;
  logic          one_rot_c;

  assign inc_c     = {1'b0, ac_q} + (W+1)'(1);
  assign one_rot_c = opr_q[B_RAR] ^ opr_q[B_RAL];

  // Next-state, writeback and micro-op datapath.
  always_comb begin
    state_d = state_q;
    opr_d   = opr_q;
    ac_d    = ac_q;
    link_d  = link_q;
    case (state_q)
      S_IDLE: begin
        if (OPR_START) begin
          opr_d   = OPR;
          state_d = S_CLR;
        end else if (LD_ADD) begin
          ac_d   = SUM;
          link_d = link_q ^ CARRY;
        end else if (LD_AND) begin
          ac_d = LOGIC;
        end else if (CLR_AC) begin
          ac_d = '0;
        end
      end
      S_CLR: begin
        if (opr_q[B_CLA]) ac_d = '0;
        if (opr_q[B_CLL]) link_d = 1'b0;
        state_d = S_CMP;
      end
      S_CMP: begin
        if (opr_q[B_CMA]) ac_d = ~ac_q;
        if (opr_q[B_CML]) link_d = ~link_q;
        state_d = S_INC;
      end
      S_INC: begin
        if (opr_q[B_IAC]) begin
          ac_d   = inc_c[W-1:0];
          link_d = link_q ^ inc_c[W];
        end
        state_d = S_ROT1;
      end
      S_ROT1, S_ROT2: begin
        // RAR with RAL cancels out; BSW with a single rotate repeats it once.
        if (opr_q[B_RAR] && !opr_q[B_RAL]) begin
          link_d = ac_q[0];
          ac_d   = {link_q, ac_q[W-1:1]};
        end else if (opr_q[B_RAL] && !opr_q[B_RAR]) begin
          link_d = ac_q[W-1];
          ac_d   = {ac_q[W-2:0], link_q};
        end
`ifdef ACC_BSW_EN
        else if (opr_q[B_BSW] && !opr_q[B_RAR] && !opr_q[B_RAL] && (state_q == S_ROT1)) begin
          ac_d = {ac_q[5:0], ac_q[11:6]};
        end
`endif
        if (state_q == S_ROT1 && opr_q[B_BSW] && one_rot_c) state_d = S_ROT2;
        else state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      state_q <= S_IDLE;
      opr_q   <= '0;
      ac_q    <= '0;
      link_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opr_q   <= opr_d;
      ac_q    <= ac_d;
      link_q  <= link_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign AC   = ac_q;
  assign LINK = link_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_acc_link_seq.sv
// Self-checking bench for acc_link_seq: arithmetic reference model plus directed literals.
module tb_acc_link_seq;

  logic        CLK, RESET_;
  logic [11:0] SUM, LOGIC;
  logic        CARRY, LD_ADD, LD_AND, CLR_AC, OPR_START;
  logic [7:0]  OPR;
  logic [11:0] AC;
  logic        LINK, BUSY, DONE;

  int checks = 0;
  int errors = 0;

  // Reference model state: m_cyc = cycles since a start was accepted (0 when idle).
  int m_ac, m_link, m_cyc, m_len;

  acc_link_seq dut (
    .CLK(CLK), .RESET_(RESET_), .SUM(SUM), .CARRY(CARRY), .LOGIC(LOGIC),
    .LD_ADD(LD_ADD), .LD_AND(LD_AND), .CLR_AC(CLR_AC), .OPR(OPR),
    .OPR_START(OPR_START), .AC(AC), .LINK(LINK), .BUSY(BUSY), .DONE(DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", nm, act, exp);
    end
  endtask

  // Net effect of a whole group-1 instruction on the 13-bit LINK:AC value.
  function automatic int opr_result(input int ac_in, input int lk_in, input logic [7:0] op);
    int ac, lk, v, n;
    ac = ac_in; lk = lk_in;
    if (op[7]) ac = 0;
    if (op[6]) lk = 0;
    if (op[5]) ac = 4095 - ac;
    if (op[4]) lk = 1 - lk;
    if (op[0]) begin
      ac = ac + 1;
      if (ac == 4096) begin ac = 0; lk = 1 - lk; end
    end
    v = lk * 4096 + ac;
    n = (op[3] != op[2]) ? (op[1] ? 2 : 1) : 0;
    for (int i = 0; i < n; i++) begin
      if (op[3]) v = (v >> 1) + (v % 2) * 4096;
      else       v = (v * 2) % 8192 + v / 4096;
    end
`ifdef ACC_BSW_EN
    if (op[1] && !op[3] && !op[2]) v = lk * 4096 + (ac % 64) * 64 + ac / 64;
`endif
    return v;
  endfunction

  function automatic int opr_len(input logic [7:0] op);
    return (op[1] && (op[3] != op[2])) ? 6 : 5;
  endfunction

  task automatic model_edge();
    int v;
    if (m_cyc != 0) begin
      if (m_cyc == m_len) m_cyc = 0;
      else m_cyc++;
    end else if (OPR_START) begin
      v = opr_result(m_ac, m_link, OPR);
      m_ac = v % 4096; m_link = v / 4096;
      m_len = opr_len(OPR); m_cyc = 1;
    end else if (LD_ADD) begin
      m_ac = int'(SUM); m_link = m_link ^ int'(CARRY);
    end else if (LD_AND) begin
      m_ac = int'(LOGIC);
    end else if (CLR_AC) begin
      m_ac = 0;
    end
  endtask

  task automatic compare();
    chk("busy", int'(BUSY), (m_cyc >= 1 && m_cyc < m_len) ? 1 : 0);
    chk("done", int'(DONE), (m_cyc != 0 && m_cyc == m_len) ? 1 : 0);
    if (m_cyc == 0 || m_cyc == m_len) begin
      chk("ac", int'(AC), m_ac);
      chk("link", int'(LINK), m_link);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare();
  endtask

  task automatic load(input logic [11:0] v, input int lk);
    LD_AND = 1'b1; LOGIC = v; tick(); LD_AND = 1'b0;
    if (m_link != lk) begin
      LD_ADD = 1'b1; SUM = v; CARRY = 1'b1; tick(); LD_ADD = 1'b0; CARRY = 1'b0;
    end
  endtask

  // Start a sequence, return start-to-DONE latency and BUSY-high count.
  task automatic run_seq(input logic [7:0] op, input bit poke_fin, output int lat, output int nbusy);
    OPR = op; OPR_START = 1'b1; tick(); OPR_START = 1'b0;
    lat = 1; nbusy = int'(BUSY);
    while (!DONE && lat < 20) begin
      tick(); lat++; nbusy += int'(BUSY);
    end
    if (!DONE) chk("done_timeout", 0, 1);
    if (poke_fin) OPR_START = 1'b1;
    tick();
    OPR_START = 1'b0;
  endtask

  task automatic model_reset();
    m_ac = 0; m_link = 0; m_cyc = 0; m_len = 5;
  endtask

  typedef struct { logic [11:0] ac; int lk; logic [7:0] op; } vec_t;
  vec_t vecs [8];

  initial begin
    int lat, nb;
    RESET_ = 1'b0; SUM = '0; LOGIC = '0; CARRY = 1'b0; OPR = '0;
    LD_ADD = 1'b0; LD_AND = 1'b0; CLR_AC = 1'b0; OPR_START = 1'b0;
    model_reset();
    @(negedge CLK); @(negedge CLK);
    chk("rst_ac", int'(AC), 0);
    chk("rst_link", int'(LINK), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    RESET_ = 1'b1;

    // Add writeback wrapping through zero with carry.
    load(12'o7777, 0);
    LD_ADD = 1'b1; SUM = 12'o0000; CARRY = 1'b1; tick(); LD_ADD = 1'b0; CARRY = 1'b0;
    chk("ladd_ac", int'(AC), 'o0000);
    chk("ladd_link", int'(LINK), 1);

    // Writeback priority in idle.
    LD_ADD = 1'b1; LD_AND = 1'b1; CLR_AC = 1'b1; SUM = 12'o0123; LOGIC = 12'o0456; tick();
    chk("prio_add", int'(AC), 'o0123);
    LD_ADD = 1'b0; tick();
    chk("prio_and", int'(AC), 'o0456);
    LD_AND = 1'b0; tick();
    chk("prio_clr", int'(AC), 'o0000);
    CLR_AC = 1'b0;

    load(12'o1234, 0);
    run_seq(8'hE1, 1'b0, lat, nb);
    chk("cla_lat", lat, 5);
    chk("cla_busy", nb, 4);
    chk("cla_ac", int'(AC), 'o0000);
    chk("cla_link", int'(LINK), 1);

    load(12'o4001, 0);
    run_seq(8'h06, 1'b0, lat, nb);
    chk("rtl_lat", lat, 6);
    chk("rtl_ac", int'(AC), 'o0005);
    chk("rtl_link", int'(LINK), 0);

    load(12'o4001, 0);
    run_seq(8'h04, 1'b1, lat, nb);
    chk("ral_lat", lat, 5);
    chk("ral_ac", int'(AC), 'o0002);
    chk("ral_link", int'(LINK), 1);
    chk("fin_start_ignored", int'(BUSY), 0);

    load(12'o1234, 0);
    run_seq(8'h02, 1'b0, lat, nb);
    chk("bsw_lat", lat, 5);
`ifdef ACC_BSW_EN
    chk("bsw_ac", int'(AC), 'o3412);
`else
    chk("bsw_ac", int'(AC), 'o1234);
`endif

    vecs[0] = '{12'o7777, 0, 8'h01};
    vecs[1] = '{12'o1234, 1, 8'h18};
    vecs[2] = '{12'o5252, 1, 8'h0C};
    vecs[3] = '{12'o0007, 0, 8'h26};
    vecs[4] = '{12'o4000, 1, 8'h0A};
    vecs[5] = '{12'o1234, 1, 8'h00};
    vecs[6] = '{12'o7776, 1, 8'h91};
    vecs[7] = '{12'o6543, 0, 8'h0E};
    foreach (vecs[i]) begin
      load(vecs[i].ac, vecs[i].lk);
      run_seq(vecs[i].op, 1'b0, lat, nb);
      chk("vec_lat", lat, opr_len(vecs[i].op));
    end

    // RTR with writeback and start strobes arriving while busy.
    load(12'o1234, 0);
    OPR = 8'h0A; OPR_START = 1'b1; tick(); OPR_START = 1'b0;
    tick();
    LD_AND = 1'b1; LOGIC = 12'o7070; OPR_START = 1'b1; tick();
    LD_AND = 1'b0; OPR_START = 1'b0;
    lat = 3;
    while (!DONE && lat < 20) begin tick(); lat++; end
    chk("rtr_lat", lat, 6);
    chk("rtr_ac", int'(AC), 'o0247);
    chk("rtr_link", int'(LINK), 0);
    tick();

    // Asynchronous reset in the middle of a sequence.
    load(12'o1234, 1);
    OPR = 8'h0A; OPR_START = 1'b1; tick(); OPR_START = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_busy", int'(BUSY), 1);
    #1 RESET_ = 1'b0;
    #1;
    chk("arst_ac", int'(AC), 0);
    chk("arst_link", int'(LINK), 0);
    chk("arst_busy", int'(BUSY), 0);
    chk("arst_done", int'(DONE), 0);
    model_reset();
    @(posedge CLK); @(negedge CLK);
    RESET_ = 1'b1;

    // First edge after reset accepts a command.
    LD_AND = 1'b1; LOGIC = 12'o0770; tick(); LD_AND = 1'b0;
    chk("post_rst_and", int'(AC), 'o0770);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
